mem_bram: RTL and testbench

// - Parametrised simple dual-port RAM: one write port, one read port, single clock; next generation of the

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_clear_fsm.sv | 62 ++++++
 rtl/mem_bram.sv | 118 +++++++++++
 tb/tb_mem_bram.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the mem_bram RAM and its clear engine.
//   state_t  : clear-engine state encoding (ST_CLEAR / ST_READY)
//   clog2    : ceiling log2, minimum 1, used for address widths
//   lanes_of : number of byte-enable lanes for a given word and lane width
package mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Ceiling log2; a one-word array still gets a 1-bit address.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

  function automatic int unsigned lanes_of(input int unsigned width,
                                           input int unsigned byte_w);
    return width / byte_w;
  endfunction

endpackage

// File: rtl/mem_clear_fsm.sv
// mem_clear_fsm: post-reset clear engine for mem_bram.
// Walks clr_addr from 0 to DEPTH-1, one word per clock, then goes READY.
// Ports:
//   clock, reset : single clock, synchronous active-high reset
//   busy         : high while clearing (registered)
//   clr_addr     : word being cleared this cycle (registered)
//   clr_we_c     : clear write strobe for the array (combinational)
module mem_clear_fsm
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned AW             = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  output logic          busy,
  output logic [AW-1:0] clr_addr,
  output logic          clr_we_c
);

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] addr_next;

  // State, address and busy registers; busy mirrors the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= RESET_STATE;
      clr_addr <= '0;
      busy     <= (RESET_STATE == ST_CLEAR);
    end else begin
      state    <= state_next;
      clr_addr <= addr_next;
      busy     <= (state_next == ST_CLEAR);
    end
  end

  // Next-state logic; no clear write is issued on a reset edge.
  always_comb begin
    state_next = state;
    addr_next  = clr_addr;
    clr_we_c   = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we_c = !reset;
        if (clr_addr == AW'(DEPTH - 1)) begin
          state_next = ST_READY;
          addr_next  = '0;
        end else begin
          addr_next = clr_addr + AW'(1);
        end
      end
      ST_READY: begin
        state_next = ST_READY;
      end
    endcase
  end

endmodule

// File: rtl/mem_bram.sv
// mem_bram: simple dual-port RAM (one write, one read port, single clock)
// with per-byte write enables, write-first same-address forwarding, a
// q_valid strobe and a post-reset clear engine.
// Optional feature: define MEM_OUTREG_EN to add an output register
// (read latency 2 instead of 1).
// Ports:
//   clock, reset      : single clock, synchronous active-high reset
//   data, wraddress   : write data / address
//   wren, byteena     : write strobe / per-lane write enables
//   rdaddress, rden   : read address / strobe
//   q, q_valid        : read data and one-cycle result strobe
//   busy              : clear engine running; requests are ignored
module mem_bram
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BYTE_W         = 8,
  parameter int unsigned DEPTH          = 256,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned AW            = clog2(DEPTH),
  localparam int unsigned LANES         = lanes_of(WIDTH, BYTE_W)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic [AW-1:0]    wraddress,
  input  logic             wren,
  input  logic [LANES-1:0] byteena,
  input  logic [AW-1:0]    rdaddress,
  input  logic             rden,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             busy
);

  (* ramstyle = "M20K" *) logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    clr_addr;
  logic             clr_we_c;
  logic             wr_ok_c;
  logic             rd_ok_c;
  logic             rd_in_range_c;
  logic             fwd_hit_c;
  logic [WIDTH-1:0] rd_word_c;
  logic [WIDTH-1:0] rd_fwd_c;
  logic [WIDTH-1:0] q_s1;
  logic             v_s1;

  mem_clear_fsm #(
    .DEPTH         (DEPTH),
    .AW            (AW),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear (
    .clock   (clock),
    .reset   (reset),
    .busy    (busy),
    .clr_addr(clr_addr),
    .clr_we_c(clr_we_c)
  );

  // Request qualification; out-of-range writes are dropped, out-of-range reads return 0.
  always_comb begin
    wr_ok_c       = wren && !busy && !reset && (32'(wraddress) < DEPTH);
    rd_ok_c       = rden && !busy && !reset;
    rd_in_range_c = 32'(rdaddress) < DEPTH;
    fwd_hit_c     = wr_ok_c && (wraddress == rdaddress);
  end

  // Array write port: clear words win; user writes are lane-masked.
  always_ff @(posedge clock) begin
    if (clr_we_c) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok_c) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (byteena[i]) mem[wraddress][i*BYTE_W +: BYTE_W] <= data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Array read plus write-first merge of the enabled lanes on an address match.
  always_comb begin
    rd_word_c = rd_in_range_c ? mem[rdaddress] : '0;
    rd_fwd_c  = rd_word_c;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (fwd_hit_c && byteena[i]) rd_fwd_c[i*BYTE_W +: BYTE_W] = data[i*BYTE_W +: BYTE_W];
    end
  end

  // First read stage: q holds its value when no read is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_s1 <= '0;
      v_s1 <= 1'b0;
    end else begin
      v_s1 <= rd_ok_c;
      if (rd_ok_c) q_s1 <= rd_fwd_c;
    end
  end

`ifdef MEM_OUTREG_EN
  // Extra output register: one more cycle of latency, full throughput.
  always_ff @(posedge clock) begin
    if (reset) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      q       <= q_s1;
      q_valid <= v_s1;
    end
  end
`else
  always_comb begin
    q       = q_s1;
    q_valid = v_s1;
  end
`endif

endmodule

// File: tb/tb_mem_bram.sv
// tb_mem_bram: directed bench for mem_bram. Two instances (DEPTH=16 and
// DEPTH=12) share one stimulus; a behavioural model per instance is
// compared every cycle, plus hand-computed literal expectations.
module tb_mem_bram;

`ifdef MEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clock;
  logic        reset;
  logic [31:0] data;
  logic [3:0]  wraddress;
  logic        wren;
  logic [3:0]  byteena;
  logic [3:0]  rdaddress;
  logic        rden;
  logic [31:0] q16, q12;
  logic        v16, v12, b16, b12;

  int checks = 0;
  int errors = 0;

  mem_bram #(.WIDTH(32), .BYTE_W(8), .DEPTH(16), .CLEAR_ON_RESET(1'b1)) u_dut16 (
    .clock(clock), .reset(reset), .data(data), .wraddress(wraddress), .wren(wren),
    .byteena(byteena), .rdaddress(rdaddress), .rden(rden),
    .q(q16), .q_valid(v16), .busy(b16)
  );

  mem_bram #(.WIDTH(32), .BYTE_W(8), .DEPTH(12), .CLEAR_ON_RESET(1'b1)) u_dut12 (
    .clock(clock), .reset(reset), .data(data), .wraddress(wraddress), .wren(wren),
    .byteena(byteena), .rdaddress(rdaddress), .rden(rden),
    .q(q12), .q_valid(v12), .busy(b12)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: memory contents, remaining clear cycles, read pipeline.
  logic [31:0] mm [2][16];
  int          bcnt [2];
  logic [31:0] s1q [2];
  logic [31:0] s2q [2];
  logic        s1v [2];
  logic        s2v [2];
  logic [31:0] eq [2];
  logic        ev [2];

  always @(posedge clock) begin
    int d;
    logic [31:0] rq;
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? 16 : 12;
      if (reset) begin
        bcnt[k] = d;
        s1q[k] = 0; s1v[k] = 0; s2q[k] = 0; s2v[k] = 0;
      end else begin
        s2q[k] = s1q[k];
        s2v[k] = s1v[k];
        if (bcnt[k] > 0) begin
          mm[k][d - bcnt[k]] = 0;
          bcnt[k] = bcnt[k] - 1;
          s1v[k] = 0;
        end else begin
          if (rden) begin
            if (int'(rdaddress) >= d) rq = 0;
            else begin
              rq = mm[k][rdaddress];
              if (wren && wraddress == rdaddress)
                for (int l = 0; l < 4; l++) if (byteena[l]) rq[l*8 +: 8] = data[l*8 +: 8];
            end
            s1q[k] = rq;
          end
          s1v[k] = rden;
          if (wren && int'(wraddress) < d)
            for (int l = 0; l < 4; l++) if (byteena[l]) mm[k][wraddress][l*8 +: 8] = data[l*8 +: 8];
        end
      end
      eq[k] = (LAT == 2) ? s2q[k] : s1q[k];
      ev[k] = (LAT == 2) ? s2v[k] : s1v[k];
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clock) begin
    #1;
    chk("cyc_q16", q16, eq[0]);
    chk("cyc_valid16", 32'(v16), 32'(ev[0]));
    chk("cyc_busy16", 32'(b16), 32'(bcnt[0] > 0));
    chk("cyc_q12", q12, eq[1]);
    chk("cyc_valid12", 32'(v12), 32'(ev[1]));
    chk("cyc_busy12", 32'(b12), 32'(bcnt[1] > 0));
  end

  // All tasks start and end at a negedge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wren = 1'b1; wraddress = a; data = d; byteena = be;
    @(negedge clock);
    wren = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e16, input logic [31:0] e12);
    rden = 1'b1; rdaddress = a;
    @(negedge clock);
    rden = 1'b0;
    repeat (LAT - 1) @(negedge clock);
    chk($sformatf("rd_q16@%0d", a), q16, e16);
    chk($sformatf("rd_valid16@%0d", a), 32'(v16), 32'd1);
    chk($sformatf("rd_q12@%0d", a), q12, e12);
    chk($sformatf("rd_valid12@%0d", a), 32'(v12), 32'd1);
  endtask

  // Counts busy cycles of the DEPTH=16 instance; optionally drives junk requests meanwhile.
  task automatic busy_phase(input bit drv, output int n);
    n = 0;
    for (int i = 0; i < 100 && b16; i++) begin
      chk("busy_no_valid16", 32'(v16), 32'd0);
      wren      = drv && (n < 10) && ($urandom_range(0, 1) == 1);
      rden      = drv && (n < 10) && ($urandom_range(0, 1) == 1);
      wraddress = 4'($urandom_range(0, 15));
      rdaddress = 4'($urandom_range(0, 15));
      data      = $urandom;
      byteena   = 4'($urandom);
      n++;
      @(negedge clock);
    end
    wren = 1'b0;
    rden = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] sq [12];
    logic        sv [12];
    reset = 1'b1; wren = 1'b0; rden = 1'b0; data = '0;
    wraddress = '0; rdaddress = '0; byteena = '0;

    // Reset values.
    @(posedge clock); #1;
    chk("reset_q", q16, 32'd0);
    chk("reset_valid", 32'(v16), 32'd0);
    chk("reset_busy", 32'(b16), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    busy_phase(1'b0, n);
    chk("busy_cycles_first", 32'(n), 32'd16);

    // Every word cleared; out-of-range reads on the small array also read 0.
    for (int a = 0; a < 16; a++) rd(4'(a), 32'd0, 32'd0);

    // Byte-lane merge.
    wr(4'd5, 32'hDEADBEEF, 4'b1111);
    wr(4'd5, 32'h000000AA, 4'b0001);
    rd(4'd5, 32'hDEADBEAA, 32'hDEADBEAA);

    // Write-first forwarding with partial lanes.
    wr(4'd3, 32'hAABBCCDD, 4'b1111);
    wren = 1'b1; wraddress = 4'd3; data = 32'h11223344; byteena = 4'b1100;
    rden = 1'b1; rdaddress = 4'd3;
    @(negedge clock);
    wren = 1'b0; rden = 1'b0;
    repeat (LAT - 1) @(negedge clock);
    chk("fwd_q16", q16, 32'h1122CCDD);
    chk("fwd_valid16", 32'(v16), 32'd1);
    rd(4'd3, 32'h1122CCDD, 32'h1122CCDD);

    // Out-of-range write on DEPTH=12; no aliasing onto entry 1.
    wr(4'd13, 32'h13131313, 4'b1111);
    rd(4'd13, 32'h13131313, 32'd0);
    rd(4'd1, 32'd0, 32'd0);

    // Streaming reads at full rate.
    for (int a = 0; a < 8; a++) wr(4'(a), 32'h10203040 + 32'(a), 4'b1111);
    @(negedge clock);
    for (int k = 0; k < 12; k++) begin
      sq[k] = q16;
      sv[k] = v16;
      rden = (k < 8);
      rdaddress = 4'(k);
      @(negedge clock);
    end
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("stream_valid[%0d]", k), 32'(sv[k]), 32'(k >= LAT && k < LAT + 8));
      if (k >= LAT && k < LAT + 8)
        chk($sformatf("stream_q[%0d]", k), sq[k], 32'h10203040 + 32'(k - LAT));
    end

    // Reset in READY zeroes q; reset mid-clear restarts the full clear.
    reset = 1'b1;
    @(posedge clock); #1;
    chk("ready_reset_q", q16, 32'd0);
    chk("ready_reset_valid", 32'(v16), 32'd0);
    chk("ready_reset_busy", 32'(b16), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    busy_phase(1'b1, n);
    chk("busy_cycles_restart", 32'(n), 32'd16);
    rd(4'd5, 32'd0, 32'd0);
    rd(4'd13, 32'd0, 32'd0);
    rd(4'd3, 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
